// File: rtl/imm_encoder.sv
// RV32I immediate encoder (I/S/B/J) feeding a 2-entry output FIFO.
// Optional range checking: define IMM_ENCODER_RANGE_CHECK_EN to enable out_err/err_count.
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_immsrc,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [7:0]  err_count
);

    // Inverse of the RV32I immediate decode; unlisted bits come from base.
    function automatic logic [31:0] encode_imm(input logic [1:0]  src,
                                               input logic [31:0] imm,
                                               input logic [31:0] base);
        logic [31:0] r;
        r = base;
        case (src)
            2'b00: r[31:20] = imm[11:0];
            2'b01: begin
                r[31:25] = imm[11:5];
                r[11:7]  = imm[4:0];
            end
            2'b10: begin
                r[31]    = imm[12];
                r[30:25] = imm[10:5];
                r[11:8]  = imm[4:1];
                r[7]     = imm[11];
            end
            2'b11: begin
                r[31]    = imm[20];
                r[30:21] = imm[10:1];
                r[20]    = imm[11];
                r[19:12] = imm[19:12];
            end
            default: r = base;
        endcase
        return r;
    endfunction

    logic [31:0] mem_instr_r [0:1];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  count_r;
    logic        in_ready_r;
    logic        out_valid_r;

    logic        push_s;
    logic        pop_s;
    logic [1:0]  count_next_s;
    logic [31:0] enc_s;

    assign push_s    = in_valid & in_ready_r;
    assign pop_s     = out_valid_r & out_ready;
    assign enc_s     = encode_imm(in_immsrc, in_imm, in_base);
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_instr = mem_instr_r[rd_ptr_r];

    // Next occupancy from the push/pop handshakes.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage, pointers, and registered handshake flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_instr_r[0] <= 32'd0;
            mem_instr_r[1] <= 32'd0;
            rd_ptr_r       <= 1'b0;
            wr_ptr_r       <= 1'b0;
            count_r        <= 2'd0;
            in_ready_r     <= 1'b0;
            out_valid_r    <= 1'b0;
        end else begin
            if (push_s) begin
                mem_instr_r[wr_ptr_r] <= enc_s;
                wr_ptr_r              <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r     <= count_next_s;
            // Flags follow next occupancy so in_ready never depends on out_ready combinationally.
            in_ready_r  <= (count_next_s != 2'd2);
            out_valid_r <= (count_next_s != 2'd0);
        end
    end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
    // True when imm does not fit the selected format (or is odd for B/J).
    function automatic logic range_bad(input logic [1:0] src, input logic [31:0] imm);
        logic bad;
        case (src)
            2'b00, 2'b01: bad = (imm[31:11] != {21{imm[31]}});
            2'b10:        bad = (imm[31:12] != {20{imm[31]}}) | imm[0];
            2'b11:        bad = (imm[31:20] != {12{imm[31]}}) | imm[0];
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction

    logic       mem_err_r [0:1];
    logic [7:0] err_count_r;
    logic       bad_s;

    assign bad_s     = range_bad(in_immsrc, in_imm);
    assign out_err   = mem_err_r[rd_ptr_r];
    assign err_count = err_count_r;

    // Per-entry error flag and saturating error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_err_r[0] <= 1'b0;
            mem_err_r[1] <= 1'b0;
            err_count_r  <= 8'd0;
        end else begin
            if (push_s) begin
                mem_err_r[wr_ptr_r] <= bad_s;
            end else begin
                mem_err_r[wr_ptr_r] <= mem_err_r[wr_ptr_r];
            end
            if (push_s && bad_s && (err_count_r != 8'd255)) begin
                err_count_r <= err_count_r + 8'd1;
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end
`else
    logic unused_imm_s;

    // Upper immediate bits only matter to the range checker.
    assign unused_imm_s = ^in_imm[31:21];
    assign out_err      = 1'b0;
    assign err_count    = 8'd0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder; expectations adapt to IMM_ENCODER_RANGE_CHECK_EN.
module tb_imm_encoder;

`ifdef IMM_ENCODER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_immsrc = 2'd0;
    logic [31:0] in_imm = 32'd0;
    logic [31:0] in_base = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic [7:0]  err_count;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    imm_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_immsrc (in_immsrc),
        .in_imm    (in_imm),
        .in_base   (in_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic note_bad(input logic bad);
        if (RC && bad && (exp_cnt != 8'd255)) exp_cnt = exp_cnt + 8'd1;
    endtask

    // Single request into an empty FIFO, then drain it; called at a negedge.
    task automatic do_one(input string tag, input logic [1:0] src, input logic [31:0] imm,
                          input logic [31:0] base, input logic [31:0] exp_instr, input logic bad);
        in_immsrc = src; in_imm = imm; in_base = base; in_valid = 1'b1; out_ready = 1'b0;
        check({tag, ".pre_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".pre_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        note_bad(bad);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".instr"}, out_instr, exp_instr);
        check({tag, ".err"}, {31'd0, out_err}, {31'd0, RC & bad});
        check({tag, ".errcnt"}, {24'd0, err_count}, {24'd0, exp_cnt});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.ready", {31'd0, in_ready}, 32'd0);
        check("rst.instr", out_instr, 32'd0);
        check("rst.err", {31'd0, out_err}, 32'd0);
        check("rst.errcnt", {24'd0, err_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rel.ready", {31'd0, in_ready}, 32'd1);

        // Format encodings
        do_one("I_m1", 2'b00, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0);
        do_one("S_8", 2'b01, 32'd8, 32'h0020_A023, 32'h0020_A423, 1'b0);
        do_one("B_m4", 2'b10, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
        do_one("J_800", 2'b11, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0);
        do_one("I_base", 2'b00, 32'd0, 32'hFFFF_FFFF, 32'h000F_FFFF, 1'b0);
        do_one("S_base", 2'b01, 32'd0, 32'hFFFF_FFFF, 32'h01FF_F07F, 1'b0);
        do_one("B_4094", 2'b10, 32'd4094, 32'h0000_0063, 32'h7E00_0FE3, 1'b0);
        do_one("J_min", 2'b11, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0);

        // Backpressure: three back-to-back requests, only two fit
        out_ready = 1'b0;
        in_valid = 1'b1; in_immsrc = 2'b00; in_imm = 32'd5; in_base = 32'h0000_0013;
        @(posedge clk); @(negedge clk);
        in_immsrc = 2'b01; in_imm = 32'hFFFF_FFF8; in_base = 32'h0000_0023;
        @(posedge clk); @(negedge clk);
        in_immsrc = 2'b11; in_imm = 32'd2; in_base = 32'h0000_006F;
        check("bp.full_ready", {31'd0, in_ready}, 32'd0);
        check("bp.head_a", out_instr, 32'h0050_0013);
        @(posedge clk); @(negedge clk);
        check("bp.hold_ready", {31'd0, in_ready}, 32'd0);
        check("bp.hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp.hold_a", out_instr, 32'h0050_0013);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("bp.head_b", out_instr, 32'hFE00_0C23);
        check("bp.ready_again", {31'd0, in_ready}, 32'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check("bp.head_c", out_instr, 32'h0020_006F);
        check("bp.c_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("bp.empty", {31'd0, out_valid}, 32'd0);

        // Occupancy 1 with simultaneous push and pop
        in_valid = 1'b1; in_immsrc = 2'b00; in_imm = 32'd1; in_base = 32'h0000_0013;
        @(posedge clk); @(negedge clk);
        in_immsrc = 2'b10; in_imm = 32'd8; in_base = 32'h0000_0063; out_ready = 1'b1;
        check("pp.head_d", out_instr, 32'h0010_0013);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check("pp.valid", {31'd0, out_valid}, 32'd1);
        check("pp.head_e", out_instr, 32'h0000_0463);
        check("pp.ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("pp.empty", {31'd0, out_valid}, 32'd0);

        // Range errors
        do_one("I_2048", 2'b00, 32'd2048, 32'h0000_0013, 32'h8000_0013, 1'b1);
        do_one("B_odd", 2'b10, 32'd3, 32'h0000_0063, 32'h0000_0163, 1'b1);

        // Saturation: stream 300 bad requests
        in_valid = 1'b1; in_immsrc = 2'b00; in_imm = 32'd2048; in_base = 32'h0000_0013;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            note_bad(1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("sat.errcnt", {24'd0, err_count}, {24'd0, exp_cnt});
        check("sat.err", {31'd0, out_err}, {31'd0, RC});
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("sat.empty", {31'd0, out_valid}, 32'd0);

        // Reset with two entries queued
        in_valid = 1'b1; in_immsrc = 2'b00; in_imm = 32'd7; in_base = 32'h0000_0013;
        @(posedge clk); @(negedge clk);
        in_imm = 32'd9;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check("mr.full", {31'd0, in_ready}, 32'd0);
        check("mr.valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mr.async_valid", {31'd0, out_valid}, 32'd0);
        check("mr.async_ready", {31'd0, in_ready}, 32'd0);
        check("mr.async_instr", out_instr, 32'd0);
        check("mr.async_errcnt", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        exp_cnt = 8'd0;
        @(negedge clk);
        check("mr.ready", {31'd0, in_ready}, 32'd1);
        check("mr.no_drain", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("mr.no_drain2", {31'd0, out_valid}, 32'd0);
        check("mr.err", {31'd0, out_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
